fpnew_noncomp_wb: RTL and testbench

//   Writeback stage directly downstream of the non-computational FP unit (SGNJ/MINMAX/CMP/CLASSIFY).

---
 rtl/fpnew_noncomp_wb.sv | 81 ++++++++
 tb/tb_fpnew_noncomp_wb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpnew_noncomp_wb.sv
// fpnew_noncomp_wb: formats non-comp FP unit results into RF words through a 2-entry FIFO with sticky fflags.
module fpnew_noncomp_wb #(
  parameter int WIDTH    = 32,
  parameter int FLEN     = 32,
  parameter int TagWidth = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    in_result_i,
  input  logic [4:0]          in_status_i,
  input  logic                in_ext_bit_i,
  input  logic [9:0]          in_class_mask_i,
  input  logic                in_is_class_i,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [FLEN-1:0]     out_data_o,
  output logic                out_int_o,
  output logic [TagWidth-1:0] out_tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);
  typedef struct packed {
    logic [FLEN-1:0]     data;
    logic                is_int;
    logic [TagWidth-1:0] tag;
    logic [4:0]          status;
  } entry_t;
  entry_t            mem [2];
  entry_t            in_entry, head;
  logic [FLEN-1:0]   boxed;
  logic              wr_ptr, rd_ptr, enq, deq;
  logic [1:0]        count, count_next;
  logic [4:0]        flags_next;
  always_comb begin
    boxed = {FLEN{in_ext_bit_i}};
    boxed[WIDTH-1:0] = in_result_i;
  end
  assign in_entry = {in_is_class_i ? FLEN'(in_class_mask_i) : boxed,
                     in_is_class_i | ~in_ext_bit_i, in_tag_i, in_status_i};
  assign head        = mem[rd_ptr];
  assign out_data_o  = head.data;
  assign out_int_o   = head.is_int;
  assign out_tag_o   = head.tag;
  assign out_valid_o = count != 2'd0;
  assign busy_o      = count != 2'd0;
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;
  assign count_next  = flush_i ? 2'd0 : count + {1'b0, enq} - {1'b0, deq};
  // clear happens before the dequeued status is merged in; flushed entries never contribute
  assign flags_next  = (fflags_clr_i ? 5'd0 : fflags_o) | ((deq & ~flush_i) ? head.status : 5'd0);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_o <= 1'b1;
      fflags_o   <= 5'd0;
    end else begin
      if (flush_i) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (enq) begin
          mem[wr_ptr] <= in_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (deq) rd_ptr <= ~rd_ptr;
      end
      count      <= count_next;
      in_ready_o <= count_next != 2'd2;
      fflags_o   <= flags_next;
    end
  end
endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// tb_fpnew_noncomp_wb: directed spec scenarios plus random traffic checked against a queue-based model.
module tb_fpnew_noncomp_wb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_result;
  logic [4:0]  in_status, in_tag, out_tag, fflags;
  logic        in_ext, in_class, in_valid, in_ready, flush, out_int, out_valid, out_ready, clr, busy;
  logic [9:0]  in_mask;
  logic [31:0] out_data;
  logic [15:0] h_result;
  logic        h_ext, h_valid, h_ready, h_int, h_valid_o, h_busy;
  logic [31:0] h_data;
  logic [4:0]  h_tag, h_flags;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] data;
    logic        is_int;
    logic [4:0]  tag;
    logic [4:0]  st;
  } ent_t;
  ent_t        q[$];
  logic        ready_m = 1'b1;
  logic [4:0]  flags_m = 5'd0;

  always #5 clk = ~clk;

  fpnew_noncomp_wb #(.WIDTH(32), .FLEN(32), .TagWidth(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_result_i(in_result), .in_status_i(in_status),
    .in_ext_bit_i(in_ext), .in_class_mask_i(in_mask), .in_is_class_i(in_class), .in_tag_i(in_tag),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush), .out_data_o(out_data),
    .out_int_o(out_int), .out_tag_o(out_tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .fflags_o(fflags), .fflags_clr_i(clr), .busy_o(busy));

  fpnew_noncomp_wb #(.WIDTH(16), .FLEN(32), .TagWidth(5)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_result_i(h_result), .in_status_i(5'd0),
    .in_ext_bit_i(h_ext), .in_class_mask_i(10'd0), .in_is_class_i(1'b0), .in_tag_i(5'd7),
    .in_valid_i(h_valid), .in_ready_o(h_ready), .flush_i(1'b0), .out_data_o(h_data),
    .out_int_o(h_int), .out_tag_o(h_tag), .out_valid_o(h_valid_o), .out_ready_i(1'b1),
    .fflags_o(h_flags), .fflags_clr_i(1'b0), .busy_o(h_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t fmt();
    ent_t e;
    e.data   = in_class ? {22'd0, in_mask} : in_result;
    e.is_int = in_class | ~in_ext;
    e.tag    = in_tag;
    e.st     = in_status;
    return e;
  endfunction

  task automatic model_update();
    logic enq_m, deq_m;
    enq_m = in_valid && ready_m;
    deq_m = q.size() != 0 && out_ready;
    if (flush) begin
      q.delete();
      if (clr) flags_m = 5'd0;
      ready_m = 1'b1;
    end else begin
      if (clr) flags_m = 5'd0;
      if (deq_m) flags_m |= q.pop_front().st;
      if (enq_m) q.push_back(fmt());
      ready_m = q.size() < 2;
    end
  endtask

  task automatic check();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(ready_m));
    chk("fflags", 32'(fflags), 32'(flags_m));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_int", 32'(out_int), 32'(q[0].is_int));
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check();
  endtask

  task automatic op(input logic [31:0] r, input logic ext, input logic cls, input logic [9:0] m,
                    input logic [4:0] tg, input logic [4:0] st);
    in_result = r; in_ext = ext; in_class = cls; in_mask = m; in_tag = tg; in_status = st; in_valid = 1'b1;
  endtask

  initial begin
    in_result = 0; in_status = 0; in_ext = 0; in_class = 0; in_mask = 0; in_tag = 0;
    in_valid = 0; flush = 0; out_ready = 0; clr = 0;
    h_result = 0; h_ext = 0; h_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_fflags", 32'(fflags), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", 32'(out_tag), 0);
    chk("rst_int", 32'(out_int), 0);
    rst_n = 1'b1;
    // 1: single SGNJ
    op(32'h3F800000, 1, 0, 0, 5'd1, 5'd0); tick();
    in_valid = 0;
    chk("t1_data", out_data, 32'h3F800000);
    chk("t1_int", 32'(out_int), 0);
    out_ready = 1; tick();
    // 2: CLASSIFY QNAN
    op(0, 1, 1, 10'h200, 5'd2, 5'd0); tick();
    in_valid = 0;
    chk("t2_data", out_data, 32'h00000200);
    chk("t2_int", 32'(out_int), 1);
    tick();
    chk("t2_drained", 32'(out_valid), 0);
    // 3: backpressure
    out_ready = 0;
    op(32'h11, 1, 0, 0, 5'd1, 5'd0); tick();
    op(32'h22, 1, 0, 0, 5'd2, 5'd0); tick();
    chk("t3_ready_low", 32'(in_ready), 0);
    op(32'h33, 1, 0, 0, 5'd3, 5'd0); tick();
    chk("t3_still_low", 32'(in_ready), 0);
    chk("t3_head1", 32'(out_tag), 1);
    out_ready = 1; tick();
    chk("t3_head2", 32'(out_tag), 2);
    tick();
    in_valid = 0;
    chk("t3_head3", 32'(out_tag), 3);
    tick();
    // 4: flags
    clr = 1; tick(); clr = 0;
    op(32'h1, 0, 0, 0, 5'd4, 5'h10); tick();
    op(32'h0, 0, 0, 0, 5'd5, 5'h01); tick();
    in_valid = 0; tick();
    chk("t4_acc", 32'(fflags), 32'h11);
    op(32'h0, 0, 0, 0, 5'd6, 5'h01); tick();
    in_valid = 0; clr = 1; tick(); clr = 0;
    chk("t4_clr_deq", 32'(fflags), 32'h01);
    // 5: flush with two entries plus same-cycle input
    out_ready = 0;
    op(32'hA, 1, 0, 0, 5'd7, 5'h10); tick();
    op(32'hB, 1, 0, 0, 5'd8, 5'h00); tick();
    op(32'hC, 1, 0, 0, 5'd9, 5'h04); flush = 1; out_ready = 1; tick();
    flush = 0; in_valid = 0;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_ready", 32'(in_ready), 1);
    chk("t5_flags", 32'(fflags), 32'h01);
    // 6: WIDTH=16 instance
    h_result = 16'h3C00; h_ext = 1; h_valid = 1; tick();
    chk("t6_box", h_data, 32'hFFFF3C00);
    chk("t6_box_int", 32'(h_int), 0);
    h_result = 16'h0001; h_ext = 0; tick();
    h_valid = 0;
    chk("t6_int_data", h_data, 32'h00000001);
    chk("t6_int", 32'(h_int), 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_class  = ($urandom_range(0, 3) == 0);
      in_mask   = 10'(1 << $urandom_range(0, 9));
      in_ext    = 1'($urandom_range(0, 1));
      in_result = $urandom;
      in_tag    = 5'($urandom);
      in_status = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      clr       = ($urandom_range(0, 9) == 0);
      tick();
    end
    // reset mid-operation
    flush = 0; clr = 0; out_ready = 0;
    op(32'h5, 1, 0, 0, 5'd3, 5'h1F); tick();
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    q.delete(); ready_m = 1'b1; flags_m = 5'd0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_flags", 32'(fflags), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
